// File: rtl/instr_encoder_stream.sv
// -----------------------------------------------------------------------------
// instr_encoder_stream
//
// Packs opcode/register/funct/immediate field bundles into 32-bit RV32I
// instruction words. This is the inverse of the pipeline's field parser and
// feeds instruction memory on the self-test and program-loader path.
//
// Each accepted bundle is encoded combinationally by format (R/I/S/B/U/J).
// The word is stored in a small FIFO together with a sequential byte address
// tag for memory write-back. A reserved format code produces a NOP (addi x0,x0,0).
//
// Optional feature macro: INSTR_ENC_RANGE_CHECK_EN
//   When defined, every push checks that the immediate fits the chosen format.
//   A violation sets a sticky Err flag that clears only on reset. The word is
//   still encoded (truncated) and pushed.
//   When undefined, Err is tied low and no check logic exists.
// -----------------------------------------------------------------------------
module instr_encoder_stream #(
  parameter int          DEPTH     = 4,   // FIFO entries, power of two, 2..16
  parameter int          ADDR_W    = 12,  // width of the byte address tag
  parameter int unsigned BASE_ADDR = 0    // first address after reset, 4-aligned
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       In_Valid,
  output logic                       In_Ready,
  input  logic [2:0]                 Fmt,
  input  logic [6:0]                 Opcode,
  input  logic [4:0]                 RD,
  input  logic [2:0]                 Funct3,
  input  logic [4:0]                 RS1,
  input  logic [4:0]                 RS2,
  input  logic [6:0]                 Funct7,
  input  logic [31:0]                Imm,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic [31:0]                Instruction,
  output logic [ADDR_W-1:0]          Addr,
  output logic [$clog2(DEPTH):0]     Level,
  output logic                       Err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [LVL_W-1:0]  FULL_LEVEL = LVL_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_TAG   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(4);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [LVL_W-1:0]  LVL_ONE    = LVL_W'(1);

  // Format codes carried on Fmt; 6 and 7 are reserved.
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]       wordMem_q [DEPTH];
  logic [ADDR_W-1:0] addrMem_q [DEPTH];

  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [ADDR_W-1:0] issueAddr_q, issueAddr_d;

  logic [31:0]       encWord;
  logic              push;
  logic              pop;
  logic              headValid;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // In_Ready comes from registered occupancy only, so a pop while full never
  // opens the input in the same cycle.
  assign headValid = (level_q != '0);
  assign In_Ready  = (level_q != FULL_LEVEL);
  assign Out_Valid = headValid;
  assign push      = In_Valid && In_Ready;
  assign pop       = headValid && Out_Ready;

  // ---------------------------------------------------------------------------
  // Field packing
  // ---------------------------------------------------------------------------
  // Per-format bit placement. Immediate bits outside a format simply drop out.
  always_comb begin
    encWord = NOP_WORD;
    case (Fmt)
      FMT_R: encWord = {Funct7, RS2, RS1, Funct3, RD, Opcode};
      FMT_I: encWord = {Imm[11:0], RS1, Funct3, RD, Opcode};
      FMT_S: encWord = {Imm[11:5], RS2, RS1, Funct3, Imm[4:0], Opcode};
      FMT_B: encWord = {Imm[12], Imm[10:5], RS2, RS1, Funct3,
                        Imm[4:1], Imm[11], Opcode};
      FMT_U: encWord = {Imm[31:12], RD, Opcode};
      FMT_J: encWord = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], RD, Opcode};
      default: encWord = NOP_WORD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // Word and address tag are captured together at push time. Stale entries
  // are never visible because the outputs are qualified by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      wordMem_q[wrPtr_q] <= encWord;
      addrMem_q[wrPtr_q] <= issueAddr_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer, occupancy and address-counter next state
  // ---------------------------------------------------------------------------
  // Pointers wrap naturally because DEPTH is a power of two. The address tag
  // wraps modulo 2^ADDR_W.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    level_d     = level_q;
    issueAddr_d = issueAddr_q;

    if (push) begin
      wrPtr_d     = wrPtr_q + PTR_ONE;
      issueAddr_d = issueAddr_q + ADDR_STEP;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Register the control state. Reset discards everything buffered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      issueAddr_q <= BASE_TAG;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      issueAddr_q <= issueAddr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Head outputs
  // ---------------------------------------------------------------------------
  // When empty, Instruction reads zero and Addr shows the next tag to be
  // issued. Right after reset that tag is BASE_ADDR.
  assign Instruction = headValid ? wordMem_q[rdPtr_q] : '0;
  assign Addr        = headValid ? addrMem_q[rdPtr_q] : issueAddr_q;
  assign Level       = level_q;

  // ---------------------------------------------------------------------------
  // Immediate range checking
  // ---------------------------------------------------------------------------
`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic signed [31:0] immS;
  logic               rangeErr;
  logic               err_q, err_d;

  assign immS = $signed(Imm);

  // Decide whether the immediate can be represented by the selected format.
  always_comb begin
    rangeErr = 1'b0;
    case (Fmt)
      FMT_R:        rangeErr = 1'b0;
      FMT_I, FMT_S: rangeErr = (immS < -32'sd2048) || (immS > 32'sd2047);
      FMT_B:        rangeErr = (immS < -32'sd4096) || (immS > 32'sd4094) ||
                               Imm[0];
      FMT_J:        rangeErr = (immS < -32'sd1048576) ||
                               (immS > 32'sd1048574) || Imm[0];
      FMT_U:        rangeErr = (Imm[11:0] != 12'h000);
      default:      rangeErr = 1'b1;
    endcase
  end

  // The error flag accumulates across pushes and clears only on reset.
  always_comb begin
    err_d = err_q | (push & rangeErr);
  end

  // Register the sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

endmodule

// File: doc/instr_encoder_stream.md
Name: instr_encoder_stream

Overview:
- Inverse of the pipeline's instruction field parser: packs opcode, register, funct and immediate fields into 32-bit RV32I instruction words.
- Sits in front of instruction memory for the self-test and program-loader path.
- Accepts one field bundle per valid/ready handshake and encodes it by format (R/I/S/B/U/J).
- Buffers encoded words in a small FIFO and tags each word with a sequential byte address for memory write-back.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- ADDR_W, 12: width of the byte address tag.
- BASE_ADDR, 0: first address issued after reset; must be 4-aligned.

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- In_Valid  input  1  field bundle valid
- In_Ready  output  1  encoder can accept a bundle
- Fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J 6,7=reserved
- Opcode  input  7  instruction[6:0]
- RD  input  5  destination register
- Funct3  input  3  funct3 field
- RS1  input  5  source register 1
- RS2  input  5  source register 2
- Funct7  input  7  funct7 field, R-type only
- Imm  input  32  immediate as a signed byte value
- Out_Valid  output  1  head word valid
- Out_Ready  input  1  consumer takes head word
- Instruction  output  32  encoded word at FIFO head
- Addr  output  ADDR_W  byte address of head word
- Level  output  $clog2(DEPTH)+1  FIFO occupancy
- Err  output  1  sticky encode error (see Optional Feature)

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Out_Valid=0, Instruction=0, Addr=BASE_ADDR, Level=0, Err=0, In_Ready=1.
  - Issue counter returns to BASE_ADDR.
  - Reset mid-operation discards all buffered words. Nothing is emitted on release.
- Handshake:
  - Push when In_Valid && In_Ready. Pop when Out_Valid && Out_Ready.
  - In_Ready = (Level != DEPTH), registered/derived from state only; it does not depend on Out_Ready that cycle.
  - When full, a same-cycle pop does not enable a push.
  - Simultaneous push and pop when not full: Level unchanged, both take effect.
- Latency: a bundle accepted at edge N appears on Instruction/Addr with Out_Valid=1 from edge N onward if the FIFO was empty. Otherwise it appears in order.
- Head outputs hold stable while Out_Valid=1 && Out_Ready=0.
- Encoding is combinational at push; the word is stored in the FIFO:
  - R: Funct7|RS2|RS1|Funct3|RD|Opcode
  - I: Imm[11:0]|RS1|Funct3|RD|Opcode
  - S: Imm[11:5]|RS2|RS1|Funct3|Imm[4:0]|Opcode
  - B: Imm[12]|Imm[10:5]|RS2|RS1|Funct3|Imm[4:1]|Imm[11]|Opcode
  - U: Imm[31:12]|RD|Opcode
  - J: Imm[20]|Imm[10:1]|Imm[11]|Imm[19:12]|RD|Opcode
  - Reserved Fmt: emits NOP 32'h00000013; all fields ignored.
  - Fields unused by a format are ignored. Immediate bits outside the format are truncated.
- Address tag:
  - Stored with the word at push time from the issue counter.
  - Counter increments by 4 per push and wraps modulo 2^ADDR_W (e.g. 0xFFC -> 0x000 for ADDR_W=12).
- FIFO pointers wrap modulo DEPTH. No overflow or underflow is possible through the handshake.

Optional Feature:
- Macro: INSTR_ENC_RANGE_CHECK_EN.
- Defined:
  - At each push, Err is set when any of these hold:
    - I/S: Imm is not in [-2048, 2047].
    - B: Imm is not in [-4096, 4094], or Imm[0]=1.
    - J: Imm is not in [-2^20, 2^20-2], or Imm[0]=1.
    - U: Imm[11:0] != 0.
    - Fmt is reserved.
  - Err is sticky until reset. The word is still encoded, truncated as above, and pushed.
- Undefined: Err is tied to 0 and no check logic is present.

Test Plan:
- R add x3,x1,x2: Fmt=0 Opcode=7'h33 RD=3 F3=0 RS1=1 RS2=2 F7=0 -> Instruction=32'h002081B3, Addr=0x000, Out_Valid the cycle after acceptance.
- I addi x5,x0,-1 (Opcode=7'h13, Imm=32'hFFFFFFFF, RD=5) followed by B beq x1,x2,+8 (Opcode=7'h63, Imm=8) -> 32'hFFF00293 @0x000, then 32'h00208463 @0x004.
- Backpressure: Out_Ready=0, push 5 bundles back-to-back -> In_Ready=0 after 4th accept, Level=4, 5th held. Then Out_Ready=1 -> words drain in order at Addr 0,4,8,C, 5th accepted and tagged 0x010.
- Simultaneous push and pop at Level=2 -> Level stays 2, order preserved. Reserved Fmt=7 -> 32'h00000013.
- Reset mid-stream: assert reset_n=0 asynchronously with Level=3 -> Out_Valid=0 and Level=0 immediately. Next accepted word is tagged BASE_ADDR.
- With INSTR_ENC_RANGE_CHECK_EN: I-type Imm=2048 -> Err=1 and stays 1, word 32'h80000293 (RD=5, Opcode=7'h13) still emitted. Without the macro: same stimulus gives Err=0.
